// File: rtl/system_stream_buffer_if.sv
// Handshake bundle between the packet receiver / bitstream parser and the stream buffer.
// Signal directions are named from the buffer's (slave) point of view.
interface system_stream_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  i_flush;
    logic                  i_wr_en;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  i_rd_en;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_empty;
    logic                  o_full;
    logic                  o_almost_full;
    logic [ADDR_WIDTH:0]   o_level;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_flush, i_wr_en, i_wr_data, i_rd_en,
        input  o_rd_data, o_empty, o_full, o_almost_full, o_level, o_overflow, o_underflow
    );

    modport slave (
        input  i_flush, i_wr_en, i_wr_data, i_rd_en,
        output o_rd_data, o_empty, o_full, o_almost_full, o_level, o_overflow, o_underflow
    );
endinterface

// File: rtl/system_stream_buffer.sv
// First-word-fall-through FIFO: synchronous-read RAM plus one head register on the output.
// Level counts both RAM words and the head word, so total capacity is exactly DEPTH.
module system_stream_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int AF_MARGIN  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    system_stream_buffer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0] LVL_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic [DATA_WIDTH-1:0] r_head;
    logic                  r_head_valid;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_ram_cnt;
    logic                  w_prefetch;
    logic [ADDR_WIDTH:0]   w_level_next;

    assign w_wr_acc   = bus.i_wr_en && !r_full;
    assign w_rd_acc   = bus.i_rd_en && r_head_valid;
    // Words still sitting in RAM, i.e. not yet moved into the head register.
    assign w_ram_cnt  = r_level - {{ADDR_WIDTH{1'b0}}, r_head_valid};
    assign w_prefetch = (!r_head_valid || w_rd_acc) && (w_ram_cnt != '0);

    always_comb begin
        w_level_next = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_next = r_level + LVL_ONE;
            2'b01:   w_level_next = r_level - LVL_ONE;
            default: w_level_next = r_level;
        endcase
    end

    // RAM write port; a flushed write never lands because the pointers reset anyway.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc && !bus.i_flush) begin
            r_mem[r_wr_ptr] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_head        <= '0;
            r_head_valid  <= 1'b0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else if (bus.i_flush) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_head_valid  <= 1'b0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            // The registered RAM read doubles as the head load, so a pop never leaves a bubble.
            if (w_prefetch) begin
                r_head       <= r_mem[r_rd_ptr];
                r_rd_ptr     <= r_rd_ptr + ADDR_WIDTH'(1);
                r_head_valid <= 1'b1;
            end else if (w_rd_acc) begin
                r_head_valid <= 1'b0;
            end
            r_level       <= w_level_next;
            r_full        <= (w_level_next == LVL_FULL);
            r_almost_full <= (w_level_next >= LVL_AF);
            if (bus.i_wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.i_rd_en && !r_head_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.o_rd_data     = r_head;
    assign bus.o_empty       = !r_head_valid;
    assign bus.o_full        = r_full;
    assign bus.o_almost_full = r_almost_full;
    assign bus.o_level       = r_level;
    assign bus.o_overflow    = r_overflow;
    assign bus.o_underflow   = r_underflow;

endmodule

// File: tb/tb_system_stream_buffer.sv
// Self-checking bench for system_stream_buffer: directed scenarios plus a randomized phase,
// all checked against a queue-based model where a word becomes presentable one edge after its write.
module tb_system_stream_buffer;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int AFM   = 16;

    logic clk;
    logic rst_n;

    system_stream_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    system_stream_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [DW-1:0] q[$];
    bit m_empty = 1'b1;
    bit m_ovf   = 1'b0;
    bit m_udf   = 1'b0;

    task automatic model_clear();
        q.delete();
        m_empty = 1'b1;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Drive one cycle of stimulus, update the model at the edge, return 1 time unit later.
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit fl);
        int prev;
        bit wa, ra;
        bus.i_wr_en   = wr;
        bus.i_wr_data = d;
        bus.i_rd_en   = rd;
        bus.i_flush   = fl;
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            wa = wr && (q.size() < DEPTH);
            ra = rd && !m_empty;
            if (wr && !wa) m_ovf = 1'b1;
            if (rd && m_empty) m_udf = 1'b1;
            prev = q.size();
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(d);
            // A word written on this edge cannot be presented until the next one.
            m_empty = (prev - (ra ? 1 : 0)) < 1;
        end
        #1;
        bus.i_wr_en = 1'b0;
        bus.i_rd_en = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0; bus.i_flush = 1'b0; bus.i_wr_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.o_rd_data !== '0)   begin n_errors++; $display("FAIL reset_data got %h want 0", bus.o_rd_data); end
        n_checks++; if (bus.o_empty !== 1'b1)   begin n_errors++; $display("FAIL reset_empty got %b want 1", bus.o_empty); end
        n_checks++; if (bus.o_full !== 1'b0)    begin n_errors++; $display("FAIL reset_full got %b want 0", bus.o_full); end
        n_checks++; if (bus.o_level !== '0)     begin n_errors++; $display("FAIL reset_level got %0d want 0", bus.o_level); end
        rst_n = 1'b1;
        for (int i = 0; i < 37; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        n_checks++; if (bus.o_level !== 11'(q.size())) begin n_errors++; $display("FAIL pre_reset_level got %0d want %0d", bus.o_level, q.size()); end
        n_checks++; if (bus.o_level !== 11'd37) begin n_errors++; $display("FAIL pre_reset_37 got %0d want 37", bus.o_level); end
        // Asynchronous reset asserted between edges must act immediately.
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++; if (bus.o_level !== '0)       begin n_errors++; $display("FAIL async_level got %0d want 0", bus.o_level); end
        n_checks++; if (bus.o_empty !== 1'b1)     begin n_errors++; $display("FAIL async_empty got %b want 1", bus.o_empty); end
        n_checks++; if (bus.o_rd_data !== '0)     begin n_errors++; $display("FAIL async_data got %h want 0", bus.o_rd_data); end
        n_checks++; if (bus.o_almost_full !== 1'b0 || bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
            n_errors++; $display("FAIL async_flags got af=%b ov=%b un=%b want 0 0 0", bus.o_almost_full, bus.o_overflow, bus.o_underflow);
        end
        #1 rst_n = 1'b1;
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        n_checks++; if (bus.o_level !== 11'd1) begin n_errors++; $display("FAIL first_write_level got %0d want 1", bus.o_level); end
        n_checks++; if (bus.o_empty !== 1'b1)  begin n_errors++; $display("FAIL first_write_empty_early got %b want 1", bus.o_empty); end
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (bus.o_empty !== 1'b0)  begin n_errors++; $display("FAIL first_write_empty got %b want 0", bus.o_empty); end
        n_checks++; if (bus.o_rd_data !== 32'hA5A5_0001) begin n_errors++; $display("FAIL first_write_data got %h want a5a50001", bus.o_rd_data); end
        step(1'b0, '0, 1'b0, 1'b1);
        $display("test_reset done: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            n_checks++;
            if (bus.o_almost_full !== (q.size() >= DEPTH - AFM) || bus.o_full !== (q.size() == DEPTH)) begin
                n_errors++;
                $display("FAIL fill_flags level=%0d got af=%b full=%b want af=%b full=%b", q.size(),
                         bus.o_almost_full, bus.o_full, q.size() >= DEPTH - AFM, q.size() == DEPTH);
            end
        end
        n_checks++; if (bus.o_level !== 11'd1024) begin n_errors++; $display("FAIL fill_level got %0d want 1024", bus.o_level); end
        n_checks++; if (bus.o_overflow !== 1'b0)  begin n_errors++; $display("FAIL fill_no_ovf got %b want 0", bus.o_overflow); end
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        n_checks++; if (bus.o_overflow !== 1'b1)  begin n_errors++; $display("FAIL overflow_flag got %b want 1", bus.o_overflow); end
        n_checks++; if (bus.o_level !== 11'd1024) begin n_errors++; $display("FAIL overflow_level got %0d want 1024", bus.o_level); end
        n_checks++; if (bus.o_rd_data !== 32'd0)  begin n_errors++; $display("FAIL overflow_head got %h want 0", bus.o_rd_data); end
        $display("test_fill done: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_full_boundary();
        step(1'b1, 32'hBEEF_0000, 1'b1, 1'b0);
        n_checks++; if (bus.o_level !== 11'd1023) begin n_errors++; $display("FAIL full_rw_level got %0d want 1023", bus.o_level); end
        n_checks++; if (bus.o_rd_data !== 32'd1)  begin n_errors++; $display("FAIL full_rw_head got %h want 1", bus.o_rd_data); end
        n_checks++; if (bus.o_full !== 1'b0 || bus.o_overflow !== 1'b1) begin
            n_errors++; $display("FAIL full_rw_flags got full=%b ov=%b want 0 1", bus.o_full, bus.o_overflow);
        end
        $display("test_full_boundary done: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_drain_wrap();
        logic [DW-1:0] seq;
        while (q.size() > 0) begin
            n_checks++;
            if (bus.o_empty !== 1'b0 || bus.o_rd_data !== q[0]) begin
                n_errors++; $display("FAIL drain_head got empty=%b data=%h want 0 %h", bus.o_empty, bus.o_rd_data, q[0]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++; if (bus.o_empty !== 1'b1 || bus.o_level !== '0) begin
            n_errors++; $display("FAIL drain_end got empty=%b level=%0d want 1 0", bus.o_empty, bus.o_level);
        end
        seq = 32'h1000_0000;
        step(1'b1, seq, 1'b0, 1'b0); seq++;
        step(1'b1, seq, 1'b0, 1'b0); seq++;
        for (int i = 0; i < 3000; i++) begin
            n_checks++;
            if (bus.o_empty !== 1'b0 || bus.o_rd_data !== 32'h1000_0000 + DW'(i)) begin
                n_errors++; $display("FAIL stream_head i=%0d got empty=%b data=%h want 0 %h", i, bus.o_empty,
                                     bus.o_rd_data, 32'h1000_0000 + DW'(i));
            end
            step(1'b1, seq, 1'b1, 1'b0); seq++;
        end
        n_checks++; if (bus.o_level !== 11'd2) begin n_errors++; $display("FAIL stream_level got %0d want 2", bus.o_level); end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (bus.o_empty !== 1'b1 || bus.o_underflow !== 1'b0) begin
            n_errors++; $display("FAIL stream_end got empty=%b un=%b want 1 0", bus.o_empty, bus.o_underflow);
        end
        $display("test_drain_wrap done: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_underflow();
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (bus.o_underflow !== 1'b1) begin n_errors++; $display("FAIL underflow_flag got %b want 1", bus.o_underflow); end
        n_checks++; if (bus.o_level !== '0)       begin n_errors++; $display("FAIL underflow_level got %0d want 0", bus.o_level); end
        repeat (5) step(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (bus.o_underflow !== 1'b1) begin n_errors++; $display("FAIL underflow_sticky got %b want 1", bus.o_underflow); end
        step(1'b0, '0, 1'b0, 1'b1);
        n_checks++; if (bus.o_underflow !== 1'b0 || bus.o_overflow !== 1'b0) begin
            n_errors++; $display("FAIL underflow_cleared got un=%b ov=%b want 0 0", bus.o_underflow, bus.o_overflow);
        end
        $display("test_underflow done: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_flush();
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 500; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        n_checks++; if (bus.o_level !== 11'd500 || bus.o_underflow !== 1'b1) begin
            n_errors++; $display("FAIL preflush got level=%0d un=%b want 500 1", bus.o_level, bus.o_underflow);
        end
        step(1'b1, 32'h5555_AAAA, 1'b1, 1'b1);
        n_checks++; if (bus.o_level !== '0 || bus.o_empty !== 1'b1) begin
            n_errors++; $display("FAIL flush_state got level=%0d empty=%b want 0 1", bus.o_level, bus.o_empty);
        end
        n_checks++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
            n_errors++; $display("FAIL flush_flags got ov=%b un=%b want 0 0", bus.o_overflow, bus.o_underflow);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (bus.o_level !== '0 || bus.o_empty !== 1'b1) begin
            n_errors++; $display("FAIL flush_no_store got level=%0d empty=%b want 0 1", bus.o_level, bus.o_empty);
        end
        $display("test_flush done: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_random();
        int wp, rp, fp;
        for (int i = 0; i < 4500; i++) begin
            if (i < 1500)      begin wp = 90; rp = 15; fp = 0; end
            else if (i < 3000) begin wp = 25; rp = 85; fp = 0; end
            else               begin wp = 55; rp = 55; fp = 2; end
            step($urandom_range(99) < wp, $urandom, $urandom_range(99) < rp, $urandom_range(999) < fp);
            n_checks++;
            if (bus.o_level !== 11'(q.size()) || bus.o_empty !== m_empty) begin
                n_errors++; $display("FAIL rand_state i=%0d got level=%0d empty=%b want %0d %b", i,
                                     bus.o_level, bus.o_empty, q.size(), m_empty);
            end
            n_checks++;
            if (bus.o_full !== (q.size() == DEPTH) || bus.o_almost_full !== (q.size() >= DEPTH - AFM)) begin
                n_errors++; $display("FAIL rand_thresh i=%0d got full=%b af=%b want %b %b", i, bus.o_full,
                                     bus.o_almost_full, q.size() == DEPTH, q.size() >= DEPTH - AFM);
            end
            n_checks++;
            if (bus.o_overflow !== m_ovf || bus.o_underflow !== m_udf) begin
                n_errors++; $display("FAIL rand_flags i=%0d got ov=%b un=%b want %b %b", i, bus.o_overflow,
                                     bus.o_underflow, m_ovf, m_udf);
            end
            if (!m_empty) begin
                n_checks++;
                if (bus.o_rd_data !== q[0]) begin
                    n_errors++; $display("FAIL rand_data i=%0d got %h want %h", i, bus.o_rd_data, q[0]);
                end
            end
        end
        $display("test_random done: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_boundary();
        test_drain_wrap();
        test_underflow();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
